id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//   ID->EX pipeline stage placed directly after RegisterFile. It registers the operands read
//   from register1/register2, the immediate, the destination fields and the control bits.
//   It applies the same-cycle WB->ID bypass, which RegisterFile does not provide.
//   It detects load-use hazards and inserts a bubble when one occurs, honours branch flush and
//   external hold, and counts the bubbles it inserts.
// PARAMETERS
//   DATA_W   32  operand/immediate width
//   REG_AW   5   register index width
//   ALUOP_W  2   ALUOp field width
//   CNT_W    16  bubble counter width (saturating)
// PORTS
//   CLK           in   1        clock, all state updates on rising edge
//   RST           in   1        synchronous reset, active-high
//   read1         in   REG_AW   rs index of instruction in ID (same value driven to RegisterFile)
//   read2         in   REG_AW   rt index of instruction in ID
//   register1     in   DATA_W   RegisterFile read data for read1
//   register2     in   DATA_W   RegisterFile read data for read2
//   uses_rt       in   1        ID instruction reads rt as a source
//   imm           in   DATA_W   sign-extended immediate
//   rd            in   REG_AW   rd field
//   RegWrite_in, MemRead_in, MemWrite_in, MemtoReg_in, ALUSrc_in, RegDst_in  in 1 each  ID control
//   ALUOp_in      in   ALUOP_W  ID ALU op
//   wb_RegWrite   in   1        WB stage write enable (same signal as RegisterFile RegWrite)
//   wb_write      in   REG_AW   WB destination index
//   wb_writeData  in   DATA_W   WB write data
//   flush         in   1        branch taken; kill the instruction in ID
//   hold          in   1        downstream stall; freeze this stage
//   stall         out  1        combinational; freeze PC and IF/ID
//   ex_valid      out  1        EX slot holds a real instruction
//   ex_a, ex_b    out  DATA_W   registered operands
//   ex_imm        out  DATA_W   registered immediate
//   ex_rs, ex_rt, ex_rd   out  REG_AW   registered indices
//   ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_RegDst  out 1  registered controls
//   ex_ALUOp      out  ALUOP_W
//   bubble_cnt    out  CNT_W    number of load-use bubbles inserted
// BEHAVIOUR
//   Reset: every ex_* output and bubble_cnt = 0 and ex_valid = 0. RST overrides all other inputs.
//   Bypass (combinational):
//     opA = (read1==0) ? 0 : (wb_RegWrite && wb_write==read1) ? wb_writeData : register1.
//     opB is formed the same way from read2/register2.
//   Hazard (combinational):
//     lu = ex_valid & ex_MemRead & ex_rt!=0 & (ex_rt==read1 | (uses_rt & ex_rt==read2)).
//     stall = (lu | hold) & ~flush.
//   Per rising edge, the first matching row applies:
//     1 RST   -> reset values.
//     2 flush -> bubble: ex_valid=0, all ex_ control bits=0, data fields don't-care (drive 0).
//     3 hold  -> all ex_* retain their values; bubble_cnt unchanged.
//     4 lu    -> bubble as in row 2; bubble_cnt += 1, saturating at all-ones.
//                The ID instruction is retained upstream through stall and re-presented next cycle.
//     5 else  -> capture: ex_valid=1, ex_a=opA, ex_b=opB, ex_rs=read1, ex_rt=read2, ex_rd=rd,
//                ex_imm=imm, and all controls from *_in.
//   Latency: 1 cycle from ID inputs to ex_* outputs. A load-use hazard costs exactly 1 bubble.
//     After the bubble ex_MemRead=0, so lu deasserts by itself on the following cycle.
//   No wrap of bubble_cnt. Register 0 never bypasses, even if wb_write==0 with wb_RegWrite=1.
//   flush and lu in the same cycle: flush wins, no count, stall=0.
//   hold and lu in the same cycle: hold wins, no count. lu is re-evaluated after hold drops.
//   RST mid-stall: next cycle outputs are at reset values and stall=0.
// TESTING
//   1 RST=1 for 2 cycles with random inputs -> ex_valid=0, all ex_*=0, bubble_cnt=0, stall=0.
//   2 Normal capture: read1=1, read2=2, register1=5, register2=7, RegWrite_in=1, wb_RegWrite=0
//     -> next cycle ex_a=5, ex_b=7, ex_rs=1, ex_rt=2, ex_valid=1.
//   3 Bypass: read1=3, register1=0, wb_RegWrite=1, wb_write=3, wb_writeData=0xDEAD -> ex_a=0xDEAD.
//     Repeat with read1=0 and wb_write=0 -> ex_a=0.
//   4 Load-use: EX holds a load with ex_rt=4; ID read1=4 -> stall=1, next cycle ex_valid=0 and
//     bubble_cnt=1. The following cycle captures the instruction with stall=0.
//     With uses_rt=0 and read2=4 only -> no stall.
//   5 Priority: lu together with flush -> stall=0, bubble, count unchanged.
//     lu together with hold for 3 cycles -> outputs frozen, then 1 bubble after hold drops.
//   6 Saturation: CNT_W=2, force 5 load-use bubbles -> bubble_cnt stops at 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with same-cycle WB->ID bypass, load-use bubble
// insertion, branch flush, external hold and a saturating bubble counter.
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [REG_AW-1:0]  read1,
    input  logic [REG_AW-1:0]  read2,
    input  logic [DATA_W-1:0]  register1,
    input  logic [DATA_W-1:0]  register2,
    input  logic               uses_rt,
    input  logic [DATA_W-1:0]  imm,
    input  logic [REG_AW-1:0]  rd,
    input  logic               RegWrite_in,
    input  logic               MemRead_in,
    input  logic               MemWrite_in,
    input  logic               MemtoReg_in,
    input  logic               ALUSrc_in,
    input  logic               RegDst_in,
    input  logic [ALUOP_W-1:0] ALUOp_in,
    input  logic               wb_RegWrite,
    input  logic [REG_AW-1:0]  wb_write,
    input  logic [DATA_W-1:0]  wb_writeData,
    input  logic               flush,
    input  logic               hold,
    output logic               stall,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_a,
    output logic [DATA_W-1:0]  ex_b,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [REG_AW-1:0]  ex_rs,
    output logic [REG_AW-1:0]  ex_rt,
    output logic [REG_AW-1:0]  ex_rd,
    output logic               ex_RegWrite,
    output logic               ex_MemRead,
    output logic               ex_MemWrite,
    output logic               ex_MemtoReg,
    output logic               ex_ALUSrc,
    output logic               ex_RegDst,
    output logic [ALUOP_W-1:0] ex_ALUOp,
    output logic [CNT_W-1:0]   bubble_cnt
);

    logic               r_valid;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [DATA_W-1:0]  r_imm;
    logic [REG_AW-1:0]  r_rs;
    logic [REG_AW-1:0]  r_rt;
    logic [REG_AW-1:0]  r_rd;
    logic               r_RegWrite;
    logic               r_MemRead;
    logic               r_MemWrite;
    logic               r_MemtoReg;
    logic               r_ALUSrc;
    logic               r_RegDst;
    logic [ALUOP_W-1:0] r_ALUOp;
    logic [CNT_W-1:0]   r_cnt;

    logic [DATA_W-1:0]  w_opA;
    logic [DATA_W-1:0]  w_opB;
    logic               w_lu;
    logic               w_bubble;

    // Register 0 is hard-wired zero, so it must never pick up a WB bypass.
    assign w_opA = (read1 == '0) ? '0 :
                   (wb_RegWrite && (wb_write == read1)) ? wb_writeData : register1;
    assign w_opB = (read2 == '0) ? '0 :
                   (wb_RegWrite && (wb_write == read2)) ? wb_writeData : register2;

    assign w_lu = r_valid & r_MemRead & (r_rt != '0) &
                  ((r_rt == read1) | (uses_rt & (r_rt == read2)));
    assign stall = (w_lu | hold) & ~flush;

    // flush beats hold; a load-use bubble only when not held
    assign w_bubble = flush | (~hold & w_lu);

    always_ff @(posedge CLK) begin
        if (RST || w_bubble) begin
            r_valid    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_imm      <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_RegWrite <= 1'b0;
            r_MemRead  <= 1'b0;
            r_MemWrite <= 1'b0;
            r_MemtoReg <= 1'b0;
            r_ALUSrc   <= 1'b0;
            r_RegDst   <= 1'b0;
            r_ALUOp    <= '0;
        end else if (!hold) begin
            r_valid    <= 1'b1;
            r_a        <= w_opA;
            r_b        <= w_opB;
            r_imm      <= imm;
            r_rs       <= read1;
            r_rt       <= read2;
            r_rd       <= rd;
            r_RegWrite <= RegWrite_in;
            r_MemRead  <= MemRead_in;
            r_MemWrite <= MemWrite_in;
            r_MemtoReg <= MemtoReg_in;
            r_ALUSrc   <= ALUSrc_in;
            r_RegDst   <= RegDst_in;
            r_ALUOp    <= ALUOp_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (!flush && !hold && w_lu && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign ex_valid    = r_valid;
    assign ex_a        = r_a;
    assign ex_b        = r_b;
    assign ex_imm      = r_imm;
    assign ex_rs       = r_rs;
    assign ex_rt       = r_rt;
    assign ex_rd       = r_rd;
    assign ex_RegWrite = r_RegWrite;
    assign ex_MemRead  = r_MemRead;
    assign ex_MemWrite = r_MemWrite;
    assign ex_MemtoReg = r_MemtoReg;
    assign ex_ALUSrc   = r_ALUSrc;
    assign ex_RegDst   = r_RegDst;
    assign ex_ALUOp    = r_ALUOp;
    assign bubble_cnt  = r_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised and directed bench for id_ex_stage; a default-width instance and a
// CNT_W=2 instance share stimulus and are checked against a behavioural model.
module tb_id_ex_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  read1, read2, rd, wb_write;
    logic [31:0] register1, register2, imm, wb_writeData;
    logic        uses_rt, wb_RegWrite, flush, hold;
    logic [5:0]  ctl_in;   // {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst}
    logic [1:0]  ALUOp_in;

    logic        stall, ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_RegDst;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [1:0]  ex_ALUOp;
    logic [15:0] bubble_cnt;

    logic        s_stall, s_valid, s_RegWrite, s_MemRead, s_MemWrite, s_MemtoReg, s_ALUSrc, s_RegDst;
    logic [31:0] s_a, s_b, s_imm;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [1:0]  s_ALUOp;
    logic [1:0]  s_cnt;

    int unsigned checks = 0;
    int unsigned failures = 0;

    always #5 CLK = ~CLK;

    id_ex_stage dut (
        .CLK(CLK), .RST(RST), .read1(read1), .read2(read2), .register1(register1), .register2(register2),
        .uses_rt(uses_rt), .imm(imm), .rd(rd),
        .RegWrite_in(ctl_in[5]), .MemRead_in(ctl_in[4]), .MemWrite_in(ctl_in[3]),
        .MemtoReg_in(ctl_in[2]), .ALUSrc_in(ctl_in[1]), .RegDst_in(ctl_in[0]), .ALUOp_in(ALUOp_in),
        .wb_RegWrite(wb_RegWrite), .wb_write(wb_write), .wb_writeData(wb_writeData),
        .flush(flush), .hold(hold), .stall(stall), .ex_valid(ex_valid),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_MemtoReg(ex_MemtoReg), .ex_ALUSrc(ex_ALUSrc), .ex_RegDst(ex_RegDst),
        .ex_ALUOp(ex_ALUOp), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.CNT_W(2)) dut_sat (
        .CLK(CLK), .RST(RST), .read1(read1), .read2(read2), .register1(register1), .register2(register2),
        .uses_rt(uses_rt), .imm(imm), .rd(rd),
        .RegWrite_in(ctl_in[5]), .MemRead_in(ctl_in[4]), .MemWrite_in(ctl_in[3]),
        .MemtoReg_in(ctl_in[2]), .ALUSrc_in(ctl_in[1]), .RegDst_in(ctl_in[0]), .ALUOp_in(ALUOp_in),
        .wb_RegWrite(wb_RegWrite), .wb_write(wb_write), .wb_writeData(wb_writeData),
        .flush(flush), .hold(hold), .stall(s_stall), .ex_valid(s_valid),
        .ex_a(s_a), .ex_b(s_b), .ex_imm(s_imm), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
        .ex_RegWrite(s_RegWrite), .ex_MemRead(s_MemRead), .ex_MemWrite(s_MemWrite),
        .ex_MemtoReg(s_MemtoReg), .ex_ALUSrc(s_ALUSrc), .ex_RegDst(s_RegDst),
        .ex_ALUOp(s_ALUOp), .bubble_cnt(s_cnt)
    );

    logic [119:0] got, s_got;
    assign got   = {ex_valid, ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_rd, ex_RegWrite, ex_MemRead,
                    ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_RegDst, ex_ALUOp};
    assign s_got = {s_valid, s_a, s_b, s_imm, s_rs, s_rt, s_rd, s_RegWrite, s_MemRead,
                    s_MemWrite, s_MemtoReg, s_ALUSrc, s_RegDst, s_ALUOp};

    // Behavioural model of the EX slot; cnt is an unbounded count of bubbles.
    typedef struct {
        logic        valid;
        logic [31:0] a, b, imm;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  ctl;
        logic [1:0]  aluop;
        int unsigned cnt;
    } ex_t;

    ex_t m;

    function automatic ex_t empty_slot(int unsigned cnt);
        ex_t e;
        e.valid = 1'b0; e.a = '0; e.b = '0; e.imm = '0;
        e.rs = '0; e.rt = '0; e.rd = '0; e.ctl = '0; e.aluop = '0; e.cnt = cnt;
        return e;
    endfunction

    function automatic logic [119:0] exp_vec();
        return {m.valid, m.a, m.b, m.imm, m.rs, m.rt, m.rd, m.ctl, m.aluop};
    endfunction

    function automatic logic [31:0] operand(logic [4:0] idx, logic [31:0] rf);
        if (idx == 0) return 32'd0;
        if (wb_RegWrite && wb_write == idx) return wb_writeData;
        return rf;
    endfunction

    function automatic bit model_lu();
        return m.valid && m.ctl[4] && m.rt != 0 && (m.rt == read1 || (uses_rt && m.rt == read2));
    endfunction

    function automatic logic exp_stall();
        return (model_lu() || hold) && !flush;
    endfunction

    function automatic logic [15:0] exp_cnt16();
        return (m.cnt > 65535) ? 16'hFFFF : 16'(m.cnt);
    endfunction

    function automatic logic [1:0] exp_cnt2();
        return (m.cnt > 3) ? 2'd3 : 2'(m.cnt);
    endfunction

    task automatic tick();
        bit lu;
        ex_t n;
        @(posedge CLK);
        lu = model_lu();
        n = m;
        if (RST) n = empty_slot(0);
        else if (flush) n = empty_slot(m.cnt);
        else if (hold) n = m;
        else if (lu) n = empty_slot(m.cnt + 1);
        else begin
            n.valid = 1'b1;
            n.a = operand(read1, register1);
            n.b = operand(read2, register2);
            n.imm = imm; n.rs = read1; n.rt = read2; n.rd = rd;
            n.ctl = ctl_in; n.aluop = ALUOp_in;
        end
        m = n;
        #1;
    endtask

    task automatic rand_inputs();
        read1 = 5'($urandom_range(0, 7));
        read2 = 5'($urandom_range(0, 7));
        rd = 5'($urandom); imm = $urandom;
        register1 = $urandom; register2 = $urandom;
        uses_rt = 1'($urandom); wb_RegWrite = 1'($urandom);
        wb_write = 5'($urandom_range(0, 7)); wb_writeData = $urandom;
        ctl_in = 6'($urandom); ALUOp_in = 2'($urandom);
    endtask

    task automatic quiet();
        rand_inputs();
        RST = 1'b0; flush = 1'b0; hold = 1'b0; wb_RegWrite = 1'b0;
        uses_rt = 1'b1; ctl_in = 6'b100000;
    endtask

    // Places a load with destination rt into EX without triggering a hazard itself.
    task automatic do_load(logic [4:0] rt);
        quiet();
        read1 = 5'd0; read2 = rt; uses_rt = 1'b0; ctl_in = 6'b110100;
        tick();
    endtask

    task automatic test_reset();
        rand_inputs();
        RST = 1'b1; flush = 1'($urandom); hold = 1'($urandom);
        tick();
        rand_inputs();
        tick();
        checks++;
        if (got !== 120'd0) begin failures++; $display("FAIL reset_ex got=%h exp=0", got); end
        checks++;
        if (bubble_cnt !== 16'd0 || s_cnt !== 2'd0) begin
            failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0", bubble_cnt, s_cnt);
        end
        hold = 1'b0; #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    endtask

    task automatic test_capture();
        quiet();
        read1 = 5'd1; read2 = 5'd2; register1 = 32'd5; register2 = 32'd7;
        tick();
        checks++;
        if ({ex_valid, ex_a, ex_b, ex_rs, ex_rt, ex_RegWrite} !== {1'b1, 32'd5, 32'd7, 5'd1, 5'd2, 1'b1}) begin
            failures++;
            $display("FAIL capture got v=%b a=%0d b=%0d rs=%0d rt=%0d rw=%b exp v=1 a=5 b=7 rs=1 rt=2 rw=1",
                     ex_valid, ex_a, ex_b, ex_rs, ex_rt, ex_RegWrite);
        end
        checks++;
        if (ex_imm !== imm || ex_rd !== rd) begin
            failures++; $display("FAIL capture_imm got=%h/%0d exp=%h/%0d", ex_imm, ex_rd, imm, rd);
        end
    endtask

    task automatic test_bypass();
        quiet();
        read1 = 5'd3; read2 = 5'd3; register1 = 32'd0; register2 = 32'd0;
        wb_RegWrite = 1'b1; wb_write = 5'd3; wb_writeData = 32'hDEAD;
        tick();
        checks++;
        if (ex_a !== 32'hDEAD || ex_b !== 32'hDEAD) begin
            failures++; $display("FAIL bypass got a=%h b=%h exp=0000dead", ex_a, ex_b);
        end
        read1 = 5'd0; read2 = 5'd0; wb_write = 5'd0; register1 = 32'h1234; register2 = 32'h5678;
        tick();
        checks++;
        if (ex_a !== 32'd0 || ex_b !== 32'd0) begin
            failures++; $display("FAIL bypass_r0 got a=%h b=%h exp=0", ex_a, ex_b);
        end
    endtask

    task automatic test_load_use();
        int unsigned base;
        do_load(5'd4);
        base = m.cnt;
        quiet();
        read1 = 5'd4; read2 = 5'd5; register1 = 32'd11; #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall); end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || bubble_cnt !== 16'(base + 1)) begin
            failures++; $display("FAIL lu_bubble got v=%b cnt=%0d exp v=0 cnt=%0d", ex_valid, bubble_cnt, base + 1);
        end
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL lu_release got=%b exp=0", stall); end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_a !== 32'd11 || ex_rs !== 5'd4) begin
            failures++; $display("FAIL lu_recapture got v=%b a=%0d rs=%0d exp v=1 a=11 rs=4", ex_valid, ex_a, ex_rs);
        end
        do_load(5'd4);
        quiet();
        read1 = 5'd6; read2 = 5'd4; uses_rt = 1'b0; #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL lu_no_rt got=%b exp=0", stall); end
        uses_rt = 1'b1; #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL lu_rt got=%b exp=1", stall); end
    endtask

    task automatic test_priority();
        int unsigned base;
        do_load(5'd4);
        base = m.cnt;
        quiet();
        read1 = 5'd4; flush = 1'b1; #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall); end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_MemRead !== 1'b0 || bubble_cnt !== 16'(base)) begin
            failures++; $display("FAIL flush_bubble got v=%b mr=%b cnt=%0d exp v=0 mr=0 cnt=%0d",
                                 ex_valid, ex_MemRead, bubble_cnt, base);
        end
        do_load(5'd4);
        quiet();
        read1 = 5'd4; hold = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (stall !== 1'b1) begin failures++; $display("FAIL hold_stall cyc=%0d got=%b exp=1", i, stall); end
            tick();
            checks++;
            if (ex_valid !== 1'b1 || ex_MemRead !== 1'b1 || ex_rt !== 5'd4 || bubble_cnt !== 16'(base)) begin
                failures++; $display("FAIL hold_frozen cyc=%0d got v=%b mr=%b rt=%0d cnt=%0d exp v=1 mr=1 rt=4 cnt=%0d",
                                     i, ex_valid, ex_MemRead, ex_rt, bubble_cnt, base);
            end
        end
        hold = 1'b0;
        tick();
        checks++;
        if (ex_valid !== 1'b0 || bubble_cnt !== 16'(base + 1)) begin
            failures++; $display("FAIL hold_then_bubble got v=%b cnt=%0d exp v=0 cnt=%0d", ex_valid, bubble_cnt, base + 1);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_rs !== 5'd4) begin
            failures++; $display("FAIL hold_then_capture got v=%b rs=%0d exp v=1 rs=4", ex_valid, ex_rs);
        end
    endtask

    task automatic test_saturation();
        quiet(); RST = 1'b1; tick();
        for (int unsigned k = 1; k <= 5; k++) begin
            do_load(5'd9);
            quiet();
            read1 = 5'd9;
            tick();
            checks++;
            if (s_cnt !== ((k > 3) ? 2'd3 : 2'(k)) || bubble_cnt !== 16'(k)) begin
                failures++; $display("FAIL saturate k=%0d got=%0d/%0d exp=%0d/%0d",
                                     k, s_cnt, bubble_cnt, (k > 3) ? 3 : k, k);
            end
        end
    endtask

    task automatic test_rst_mid_stall();
        do_load(5'd7);
        quiet();
        read1 = 5'd7; #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL rst_pre_stall got=%b exp=1", stall); end
        RST = 1'b1;
        tick();
        checks++;
        if (got !== 120'd0 || bubble_cnt !== 16'd0 || stall !== 1'b0) begin
            failures++; $display("FAIL rst_mid_stall got v=%b cnt=%0d stall=%b exp 0/0/0", ex_valid, bubble_cnt, stall);
        end
        RST = 1'b0;
    endtask

    task automatic test_random();
        for (int unsigned i = 0; i < 400; i++) begin
            rand_inputs();
            ctl_in[4] = ($urandom_range(0, 1) == 0);
            RST   = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 99) < 10);
            hold  = ($urandom_range(0, 99) < 15);
            #1;
            checks++;
            if (stall !== exp_stall() || s_stall !== exp_stall()) begin
                failures++; $display("FAIL rand_stall i=%0d got=%b/%b exp=%b", i, stall, s_stall, exp_stall());
            end
            tick();
            checks++;
            if (got !== exp_vec() || s_got !== exp_vec()) begin
                failures++; $display("FAIL rand_ex i=%0d got=%h exp=%h", i, got, exp_vec());
            end
            checks++;
            if (bubble_cnt !== exp_cnt16() || s_cnt !== exp_cnt2()) begin
                failures++; $display("FAIL rand_cnt i=%0d got=%0d/%0d exp=%0d/%0d",
                                     i, bubble_cnt, s_cnt, exp_cnt16(), exp_cnt2());
            end
        end
    endtask

    initial begin
        m = empty_slot(0);
        quiet();
        test_reset();
        test_capture();
        test_bypass();
        test_load_use();
        test_priority();
        test_saturation();
        test_rst_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
